// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: binary and Gray write
// pointers, memory strobe, and full/almost-full/level/overflow against the synced read pointer.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  clr_ovf,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  wclken,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  overflow
);

   localparam int            PW    = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);
   // Full when the write Gray pointer equals the read Gray pointer with its two MSBs flipped.
   localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] wlevel_next;
   logic          full_next;
   logic          almost_full_next;

   assign wclken = wr_en & ~full & rst_n;
   assign waddr  = wbin[ADDR_WIDTH-1:0];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i < PW; i++) rbin_s[i] = ^(wq2_rptr >> i);
   end

   always_comb begin
      wbin_next        = wbin + {{(PW-1){1'b0}}, wclken};
      wgray_next       = (wbin_next >> 1) ^ wbin_next;
      full_next        = (wgray_next == (wq2_rptr ^ FULL_MASK));
      wlevel_next      = wbin_next - rbin_s;
      almost_full_next = (wlevel_next >= AF_TH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbin        <= '0;
         wptr        <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wlevel      <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wptr        <= wgray_next;
         full        <= full_next;
         almost_full <= almost_full_next;
         wlevel      <= wlevel_next;
         // A rejected write outranks a clear arriving in the same cycle.
         if (wr_en && full)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomized bench for fifo_wr_ctrl; reference model tracks write/read counts as plain integers.
module tb_fifo_wr_ctrl;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 6;
   localparam int MODP  = 2 * DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          clr_ovf = 1'b0;
   logic [AW:0]   wq2_rptr = '0;
   logic [AW-1:0] waddr;
   logic          wclken;
   logic [AW:0]   wptr;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wlevel;
   logic          overflow;

   fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .clr_ovf(clr_ovf), .wq2_rptr(wq2_rptr),
      .waddr(waddr), .wclken(wclken), .wptr(wptr), .full(full),
      .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Model: total accepted writes, total reads visible to the write side.
   int m_wcnt = 0;
   int rcnt   = 0;
   int m_lvl  = 0;
   bit m_ovf  = 1'b0;

   function automatic logic [AW:0] to_gray(input int n);
      logic [AW:0] b;
      b = (AW+1)'(n % MODP);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit we, input bit clr, input bit rst);
      bit m_full;
      @(negedge clk);
      wr_en    = we;
      clr_ovf  = clr;
      rst_n    = rst;
      wq2_rptr = to_gray(rcnt);
      #1;
      m_full = (m_lvl == DEPTH);
      chk("wclken", 32'(wclken), 32'(we && !m_full && rst));
      if (rst) chk("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
      @(posedge clk);
      if (!rst) begin
         m_wcnt = 0;
         m_lvl  = 0;
         m_ovf  = 1'b0;
      end else begin
         if (we && m_full) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (we && !m_full) m_wcnt++;
         m_lvl = ((m_wcnt - rcnt) % MODP + MODP) % MODP;
      end
      #1;
      chk("wptr", 32'(wptr), 32'(to_gray(m_wcnt)));
      chk("full", 32'(full), 32'(m_lvl == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(m_lvl >= AF));
      chk("wlevel", 32'(wlevel), 32'(m_lvl));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   initial begin
      // Reset with write requested: nothing is accepted, everything reads zero.
      rcnt = 0;
      step(1, 0, 0);
      step(1, 0, 0);
      // Fill to full from empty.
      repeat (DEPTH) step(1, 0, 1);
      chk("fill_full", 32'(full), 32'd1);
      // Overflow set, hold, clear, and set-beats-clear.
      step(1, 0, 1);
      step(0, 0, 1);
      step(0, 1, 1);
      step(1, 1, 1);
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      step(0, 1, 1);
      // Release: read side shows three entries consumed.
      rcnt = 3;
      step(0, 0, 1);
      step(1, 0, 1);
      chk("release_level", 32'(wlevel), 32'd6);
      // Wrap: drain to empty at count 8, then write 8 more through the pointer wrap.
      rst_n = 1'b1;
      step(0, 0, 0);
      rcnt = 0;
      repeat (DEPTH) step(1, 0, 1);
      rcnt = DEPTH;
      step(0, 0, 1);
      repeat (DEPTH) step(1, 0, 1);
      chk("wrap_wptr", 32'(wptr), 32'd0);
      // Mid-operation reset.
      rcnt = 0;
      step(0, 0, 0);
      repeat (5) step(1, 0, 1);
      step(1, 0, 0);
      step(1, 0, 1);
      chk("post_rst_wptr", 32'(wptr), 32'd1);
      // Random traffic with occasional resets; read side never overtakes the writer.
      for (int it = 0; it < 2000; it++) begin
         if ($urandom_range(0, 99) < 2) begin
            rcnt = 0;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         end else begin
            if (rcnt < m_wcnt && $urandom_range(0, 2) == 0) rcnt++;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
